fetch_responder: RTL and testbench

Datapath-side responder to the central sequencer's enable vector. It consumes the one-hot/multi-hot `inst_en` strobes (PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN) and performs the work they request:

- fetches instruction words from memory over a request/valid handshake;
- buffers them and loads the instruction register;
- returns the decoded 3-bit `op` to the sequencer with a valid strobe.

It sits between the central control unit and instruction memory.

---
 rtl/fetch_responder_if.sv | 25 ++
 rtl/fetch_responder.sv | 208 ++++++++++++++++++++
 tb/tb_fetch_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_responder_if.sv
// Instruction-memory read port used by fetch_responder: registered address,
// one-cycle read pulse, and returned data qualified by a valid strobe.
interface fetch_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/fetch_responder.sv
// Datapath responder to the sequencer's enable vector: fetches, buffers and decodes
// instruction words. Optional macro FETCH_TIMEOUT_EN adds a WAIT timeout and sticky fetch_err.
module fetch_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [5:0]          inst_en,
  fetch_responder_if.master   mem,
  output logic [2:0]          op,
  output logic                op_valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   x,
  output logic [DATA_W-1:0]   y,
  output logic                busy,
  output logic                fetch_err
);

  localparam int OPND_W = DATA_W - 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ibuf_q, ibuf_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [2:0]        op_q, op_d;
  logic              ibuf_full_q, ibuf_full_d;
  logic              op_valid_q, op_valid_d;
  logic              mem_rd_q, mem_rd_d;

  logic pc_en, inst_en_b, addr_en, y_en, op_en, x_en;
  logic start, capture, timeout;
  logic [ADDR_W-1:0] opnd_addr;

  assign pc_en     = inst_en[5];
  assign inst_en_b = inst_en[4];
  assign addr_en   = inst_en[3];
  assign y_en      = inst_en[2];
  assign op_en     = inst_en[1];
  assign x_en      = inst_en[0];

  // A full buffer only blocks a new fetch when INST_EN is not draining it this cycle.
  assign start   = (state_q == S_IDLE) && pc_en && (!ibuf_full_q || inst_en_b);
  assign capture = (state_q == S_WAIT) && mem.mem_rvalid;

  // Operand field zero-extended or truncated to the address width.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_opnd_addr
      if (gi < OPND_W) begin : g_bit
        assign opnd_addr[gi] = ir_q[gi];
      end else begin : g_zero
        assign opnd_addr[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;

  // The counter restarts whenever WAIT is not occupied, so it reads 0 on entry.
  assign timeout = (state_q == S_WAIT) && !mem.mem_rvalid &&
                   (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_d  = '0;
    fetch_err_d = fetch_err_q | timeout;
    if (state_q == S_WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    ibuf_d      = ibuf_q;
    ibuf_full_d = ibuf_full_q;
    ir_d        = ir_q;
    addr_d      = addr_q;
    op_d        = op_q;
    op_valid_d  = 1'b0;
    x_d         = x_q;
    y_d         = y_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_REQ;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (capture) begin
          state_d = S_IDLE;
          ibuf_d  = mem.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          if (!inst_en_b) begin
            ibuf_full_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A word arriving with INST_EN bypasses the buffer straight into ir.
    if (inst_en_b) begin
      if (capture) begin
        ir_d = mem.mem_rdata;
      end else if (ibuf_full_q) begin
        ir_d        = ibuf_q;
        ibuf_full_d = 1'b0;
      end
    end

    if (addr_en) begin
      addr_d = opnd_addr;
    end
    if (op_en) begin
      op_d       = ir_q[DATA_W-1:DATA_W-3];
      op_valid_d = 1'b1;
    end
    if (x_en) begin
      x_d = {3'b000, ir_q[OPND_W-1:0]};
    end
    if (y_en) begin
      y_d = x_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      ibuf_q      <= '0;
      ibuf_full_q <= 1'b0;
      ir_q        <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      op_valid_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      ibuf_q      <= ibuf_d;
      ibuf_full_q <= ibuf_full_d;
      ir_q        <= ir_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign op           = op_q;
  assign op_valid     = op_valid_q;
  assign addr         = addr_q;
  assign x            = x_q;
  assign y            = y_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder: a vector table for the enable/fetch behaviour plus
// hand sequences for PC wrap, reset during WAIT and the optional fetch timeout.
module tb_fetch_responder;

  logic       clk;
  logic       clr;
  logic [5:0] inst_en;
  logic [2:0] op;
  logic       op_valid;
  logic [7:0] addr;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  fetch_responder #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .clr       (clr),
    .inst_en   (inst_en),
    .mem       (bus),
    .op        (op),
    .op_valid  (op_valid),
    .addr      (addr),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] en;
    logic       rv;
    logic [7:0] rdata;
    logic [7:0] e_maddr;
    logic       e_rd;
    logic       e_busy;
    logic [2:0] e_op;
    logic       e_opv;
    logic [7:0] e_addr;
    logic [7:0] e_x;
    logic [7:0] e_y;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [5:0] en, input logic rv, input logic [7:0] rdata,
                              input logic [7:0] ma, input logic rd, input logic bsy,
                              input logic [2:0] eop, input logic eopv, input logic [7:0] ead,
                              input logic [7:0] ex, input logic [7:0] ey);
    vec_t v;
    v.en = en; v.rv = rv; v.rdata = rdata;
    v.e_maddr = ma; v.e_rd = rd; v.e_busy = bsy; v.e_op = eop; v.e_opv = eopv;
    v.e_addr = ead; v.e_x = ex; v.e_y = ey;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // PC_EN cycle (checks the read pulse and address) followed by the REQ cycle.
  task automatic start_fetch(input logic [5:0] en, input logic [7:0] exp_addr);
    @(negedge clk);
    inst_en = en;
    bus.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("start mem_rd", 32'(bus.mem_rd), 32'd1);
    check("start mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    check("start busy", 32'(busy), 32'd1);
    @(negedge clk);
    inst_en = 6'b000000;
    @(posedge clk); #1;
    check("req mem_rd", 32'(bus.mem_rd), 32'd0);
  endtask

  task automatic finish_fetch(input logic [7:0] data);
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    @(posedge clk); #1;
    check("capture busy", 32'(busy), 32'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inst_en = 6'b000000;
      bus.mem_rvalid = 1'b0;
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    // en, rv, rdata | mem_addr, mem_rd, busy, op, op_valid, addr, x, y
    vecs[0]  = mk(6'b100000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00);
    vecs[1]  = mk(6'b000000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00);
    vecs[2]  = mk(6'b000000, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00);
    vecs[3]  = mk(6'b111111, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1, 3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
    vecs[4]  = mk(6'b001111, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 3'd2, 1'b1, 8'h1A, 8'h1A, 8'h00);
    vecs[5]  = mk(6'b010000, 1'b1, 8'hE3, 8'h01, 1'b0, 1'b0, 3'd2, 1'b0, 8'h1A, 8'h1A, 8'h00);
    vecs[6]  = mk(6'b000111, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 3'd7, 1'b1, 8'h1A, 8'h03, 8'h1A);
    vecs[7]  = mk(6'b000000, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[8]  = mk(6'b100000, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[9]  = mk(6'b000000, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[10] = mk(6'b100000, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[11] = mk(6'b000000, 1'b1, 8'h21, 8'h02, 1'b0, 1'b0, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[12] = mk(6'b100000, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[13] = mk(6'b000000, 1'b1, 8'hFF, 8'h02, 1'b0, 1'b0, 3'd7, 1'b0, 8'h1A, 8'h03, 8'h1A);
    vecs[14] = mk(6'b010010, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 3'd7, 1'b1, 8'h1A, 8'h03, 8'h1A);
    vecs[15] = mk(6'b000011, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 3'd1, 1'b1, 8'h1A, 8'h01, 8'h1A);
    vecs[16] = mk(6'b001100, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 3'd1, 1'b0, 8'h01, 8'h01, 8'h01);
    vecs[17] = mk(6'b100000, 1'b0, 8'h00, 8'h03, 1'b1, 1'b1, 3'd1, 1'b0, 8'h01, 8'h01, 8'h01);
    vecs[18] = mk(6'b000000, 1'b0, 8'h00, 8'h03, 1'b0, 1'b1, 3'd1, 1'b0, 8'h01, 8'h01, 8'h01);
    vecs[19] = mk(6'b010000, 1'b1, 8'hC4, 8'h03, 1'b0, 1'b0, 3'd1, 1'b0, 8'h01, 8'h01, 8'h01);
    vecs[20] = mk(6'b000011, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 3'd6, 1'b1, 8'h01, 8'h04, 8'h01);

    clr = 1'b0;
    inst_en = 6'b000000;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem_rd", 32'(bus.mem_rd), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset op", 32'(op), 32'd0);
    check("reset op_valid", 32'(op_valid), 32'd0);
    check("reset addr", 32'(addr), 32'd0);
    check("reset x", 32'(x), 32'd0);
    check("reset y", 32'(y), 32'd0);
    check("reset fetch_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      inst_en        = vecs[i].en;
      bus.mem_rvalid = vecs[i].rv;
      bus.mem_rdata  = vecs[i].rdata;
      @(posedge clk); #1;
      $display("vec %0d en=%b rv=%b rdata=%h -> mem_addr=%h rd=%b busy=%b op=%0d opv=%b addr=%h x=%h y=%h",
               i, vecs[i].en, vecs[i].rv, vecs[i].rdata, bus.mem_addr, bus.mem_rd, busy,
               op, op_valid, addr, x, y);
      check($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_maddr));
      check($sformatf("v%0d mem_rd", i), 32'(bus.mem_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d op", i), 32'(op), 32'(vecs[i].e_op));
      check($sformatf("v%0d op_valid", i), 32'(op_valid), 32'(vecs[i].e_opv));
      check($sformatf("v%0d addr", i), 32'(addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d x", i), 32'(x), 32'(vecs[i].e_x));
      check($sformatf("v%0d y", i), 32'(y), 32'(vecs[i].e_y));
    end
    @(negedge clk);
    inst_en = 6'b000000;
    bus.mem_rvalid = 1'b0;

    // Walk pc from 0x04 through 0xFF, then confirm the wrap to 0x00.
    for (int k = 4; k < 256; k++) begin
      start_fetch(6'b110000, 8'(k));
      finish_fetch(8'(k));
    end
    $display("wrap fetch at pc=ff done");
    start_fetch(6'b110000, 8'h00);
    finish_fetch(8'h11);

    // Reset while in WAIT; a late mem_rvalid must not be captured.
    start_fetch(6'b110000, 8'h01);
    @(negedge clk);
    clr = 1'b0;
    #2;
    check("rst_wait busy", 32'(busy), 32'd0);
    check("rst_wait mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wait x", 32'(x), 32'd0);
    check("rst_wait op", 32'(op), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 8'h77;
    @(posedge clk); #1;
    check("late_rvalid busy", 32'(busy), 32'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    $display("reset during wait done");
    start_fetch(6'b100000, 8'h00);
    finish_fetch(8'h5A);

`ifdef FETCH_TIMEOUT_EN
    // Capture on the 15th WAIT cycle wins over the timeout.
    start_fetch(6'b110000, 8'h01);
    idle_cycles(14);
    check("tmo_edge busy", 32'(busy), 32'd1);
    finish_fetch(8'h42);
    check("tmo_edge fetch_err", 32'(fetch_err), 32'd0);
    start_fetch(6'b110000, 8'h02);
    idle_cycles(14);
    check("tmo pre busy", 32'(busy), 32'd1);
    check("tmo pre fetch_err", 32'(fetch_err), 32'd0);
    idle_cycles(1);
    check("tmo busy", 32'(busy), 32'd0);
    check("tmo fetch_err", 32'(fetch_err), 32'd1);
    start_fetch(6'b110000, 8'h02);
    idle_cycles(1);
    check("tmo sticky fetch_err", 32'(fetch_err), 32'd1);
    $display("timeout sequence done");
`else
    start_fetch(6'b110000, 8'h01);
    idle_cycles(20);
    check("no_tmo busy", 32'(busy), 32'd1);
    check("no_tmo fetch_err", 32'(fetch_err), 32'd0);
    $display("wait without timeout done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
